// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer: FSM states, unit codes,
// the six-digit BCD time record, and the one-second BCD borrow chain.
// Pure combinational helpers; no state and no flow control.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] UNIT_H = 2'd0;
  localparam logic [1:0] UNIT_M = 2'd1;
  localparam logic [1:0] UNIT_S = 2'd2;

  // Largest tens digit for seconds and minutes.
  localparam logic [3:0] MAX_SM = 4'd5;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  // 0..15 binary to two BCD digits {tens, ones}.
  function automatic logic [7:0] to_bcd2(input logic [3:0] v);
    if (v >= 4'd10) return {4'd1, v - 4'd10};
    else            return {4'd0, v};
  endfunction

  // Subtract one second. Never called on 00:00:00: the tick that reaches
  // zero moves the FSM to DONE, so the hours borrow cannot underflow.
  function automatic bcd_time_t dec_time(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s0 != 4'd0) r.s0 = t.s0 - 4'd1;
    else begin
      r.s0 = 4'd9;
      if (t.s1 != 4'd0) r.s1 = t.s1 - 4'd1;
      else begin
        r.s1 = MAX_SM;
        if (t.m0 != 4'd0) r.m0 = t.m0 - 4'd1;
        else begin
          r.m0 = 4'd9;
          if (t.m1 != 4'd0) r.m1 = t.m1 - 4'd1;
          else begin
            r.m1 = MAX_SM;
            if (t.h0 != 4'd0) r.h0 = t.h0 - 4'd1;
            else begin
              r.h0 = 4'd9;
              r.h1 = t.h1 - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic is_zero(input bcd_time_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while en, pulses tick on the wrap cycle.
// Latency: tick is combinational from the held count; clr wins over en.
// Backpressure: none; en low simply freezes the count.
// Ports: clk, reset (async high), clr (sync clear), en (count enable), tick (wrap pulse).
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] count_q, count_d;

  assign tick = en && !clr && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (tick) count_d = '0;
    else if (en)   count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS BCD countdown loaded from a single 4-bit value + unit; flags expiry.
// Latency: every output is registered, visible one cycle after the input is sampled.
// Backpressure: none; start is honoured only in IDLE/DONE (rej pulse on a bad setting).
// Ports: clk, reset (async high), start/unit_sel/value (load), pause (level),
//        cancel (abort/ack), busy/expired/done/rej (status), h1..s0 (BCD digits).
module countdown_timer #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] unit_sel,
  input  logic [3:0] value,
  input  logic       pause,
  input  logic       cancel,
  output logic       busy,
  output logic       expired,
  output logic       done,
  output logic       rej,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0
);
  import timer_pkg::*;

  state_t    state_q, state_d;
  bcd_time_t time_q, time_d;
  logic      busy_q, busy_d;
  logic      expired_q, expired_d;
  logic      done_q, done_d;
  logic      rej_q, rej_d;

  logic      can_load, valid_req, pre_clr, pre_en, tick;
  bcd_time_t load_t, dec_t;

  assign can_load  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign valid_req = start && (unit_sel != 2'd3) && (value != 4'd0);

  // The prescaler also counts on the PAUSED->RUN release cycle, so a pause
  // delays the next tick by exactly the number of cycles pause was high.
  assign pre_clr = cancel || (can_load && valid_req);
  assign pre_en  = !cancel && !pause &&
                   ((state_q == ST_RUN) || (state_q == ST_PAUSED));

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  assign dec_t = dec_time(time_q);

  always_comb begin
    load_t = '0;
    case (unit_sel)
      UNIT_H:  {load_t.h1, load_t.h0} = to_bcd2(value);
      UNIT_M:  {load_t.m1, load_t.m0} = to_bcd2(value);
      UNIT_S:  {load_t.s1, load_t.s0} = to_bcd2(value);
      default: load_t = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    if (cancel) begin
      state_d = ST_IDLE;
      time_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (valid_req) begin
              state_d = ST_RUN;
              time_d  = load_t;
            end else begin
              rej_d = 1'b1;
            end
          end
        end
        ST_RUN, ST_PAUSED: begin
          if (pause) begin
            // A tick coinciding with pause is discarded (prescaler held).
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RUN;
            if (tick) begin
              time_d = dec_t;
              if (is_zero(dec_t)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d    = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    expired_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      done_q    <= done_d;
      rej_q     <= rej_d;
    end
  end

  assign busy    = busy_q;
  assign expired = expired_q;
  assign done    = done_q;
  assign rej     = rej_q;
  assign h1      = time_q.h1;
  assign h0      = time_q.h0;
  assign m1      = time_q.m1;
  assign m0      = time_q.m0;
  assign s1      = time_q.s1;
  assign s0      = time_q.s0;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with CLK_HZ=4: stimulus queues
// {cycle, digits, flags} expectations; a negedge monitor checks them.
// Flags are packed {busy, expired, done, rej}.
module tb_countdown_timer;

  localparam logic [3:0] F_IDLE   = 4'b0000;
  localparam logic [3:0] F_BUSY   = 4'b1000;
  localparam logic [3:0] F_DONE   = 4'b0110;
  localparam logic [3:0] F_EXP    = 4'b0100;
  localparam logic [3:0] F_REJ    = 4'b0001;
  localparam logic [3:0] F_EXPREJ = 4'b0101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] unit_sel = 2'd0;
  logic [3:0] value = 4'd0;
  logic       pause = 1'b0;
  logic       cancel = 1'b0;
  logic       busy, expired, done, rej;
  logic [3:0] h1, h0, m1, m0, s1, s0;

  countdown_timer #(.CLK_HZ(4)) dut (
    .clk(clk), .reset(reset), .start(start), .unit_sel(unit_sel),
    .value(value), .pause(pause), .cancel(cancel),
    .busy(busy), .expired(expired), .done(done), .rej(rej),
    .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [23:0] t;
    logic [3:0]  f;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  wire [23:0] got_t = {h1, h0, m1, m0, s1, s0};
  wire [3:0]  got_f = {busy, expired, done, rej};

  function automatic void push_exp(input int c, input logic [23:0] t,
                                   input logic [3:0] f, input string name);
    exp_t e;
    e.cyc = c; e.t = t; e.f = f; e.name = name;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc != cyc || got_t !== sb[i].t || got_f !== sb[i].f) begin
          errors++;
          $display("FAIL %s cyc=%0d: got time=%h flags=%b, required time=%h flags=%b (due cyc %0d)",
                   sb[i].name, cyc, got_t, got_f, sb[i].t, sb[i].f, sb[i].cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Issue a one-cycle start; L is the edge that samples it.
  task automatic do_start(input logic [1:0] u, input logic [3:0] v, output int L);
    L = cyc + 1;
    start = 1'b1; unit_sel = u; value = v;
    step();
    start = 1'b0;
  endtask

  int L;

  initial begin
    // Reset state
    step(); step();
    push_exp(cyc, 24'h000000, F_IDLE, "reset_state");
    step();
    reset = 1'b0;
    step();

    // Seconds load: 3 s
    do_start(2'd2, 4'd3, L);
    checks++;
    if (got_t !== 24'h000003 || got_f !== F_BUSY) begin
      errors++;
      $display("FAIL sec_load_direct: got time=%h flags=%b", got_t, got_f);
    end
    push_exp(L,      24'h000003, F_BUSY, "sec_load");
    push_exp(L + 3,  24'h000003, F_BUSY, "sec_hold_before_tick");
    push_exp(L + 4,  24'h000002, F_BUSY, "sec_first_dec");
    push_exp(L + 8,  24'h000001, F_BUSY, "sec_second_dec");
    push_exp(L + 11, 24'h000001, F_BUSY, "sec_before_zero");
    push_exp(L + 12, 24'h000000, F_DONE, "sec_done_pulse");
    push_exp(L + 13, 24'h000000, F_EXP,  "sec_expired_level");
    wait_until(L + 14);

    // Minute borrow from DONE: 2 min
    do_start(2'd1, 4'd2, L);
    push_exp(L,       24'h000200, F_BUSY, "min_load");
    push_exp(L + 4,   24'h000159, F_BUSY, "min_borrow");
    push_exp(L + 8,   24'h000158, F_BUSY, "min_second_tick");
    push_exp(L + 240, 24'h000100, F_BUSY, "min_halfway");
    push_exp(L + 476, 24'h000001, F_BUSY, "min_last_second");
    push_exp(L + 480, 24'h000000, F_DONE, "min_done");
    push_exp(L + 481, 24'h000000, F_EXP,  "min_expired");
    wait_until(L + 482);

    // Hour borrow: 15 h, then cancel
    do_start(2'd0, 4'd15, L);
    push_exp(L,     24'h150000, F_BUSY, "hour_load");
    push_exp(L + 4, 24'h145959, F_BUSY, "hour_borrow");
    push_exp(L + 8, 24'h145958, F_BUSY, "hour_second_tick");
    wait_until(L + 9);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (got_t !== 24'h000000 || got_f !== F_IDLE) begin
      errors++;
      $display("FAIL hour_cancel_direct: got time=%h flags=%b", got_t, got_f);
    end
    push_exp(L + 10, 24'h000000, F_IDLE, "hour_cancel");

    // Pause for 10 cycles mid-run, then cancel together with start
    step();
    do_start(2'd2, 4'd9, L);
    push_exp(L,      24'h000009, F_BUSY, "pause_load");
    push_exp(L + 4,  24'h000008, F_BUSY, "pause_first_dec");
    wait_until(L + 5);
    pause = 1'b1;
    push_exp(L + 10, 24'h000008, F_BUSY, "pause_frozen");
    wait_until(L + 15);
    pause = 1'b0;
    push_exp(L + 17, 24'h000008, F_BUSY, "pause_not_yet");
    push_exp(L + 18, 24'h000007, F_BUSY, "pause_late_dec");
    wait_until(L + 19);
    cancel = 1'b1; start = 1'b1; unit_sel = 2'd2; value = 4'd5;
    step();
    cancel = 1'b0; start = 1'b0;
    push_exp(L + 20, 24'h000000, F_IDLE, "cancel_start_idle");
    push_exp(L + 21, 24'h000000, F_IDLE, "cancel_no_done");
    push_exp(L + 25, 24'h000000, F_IDLE, "cancel_stays_idle");
    wait_until(L + 26);

    // Rejected starts in IDLE
    do_start(2'd2, 4'd0, L);
    push_exp(L,     24'h000000, F_REJ,  "rej_value0");
    push_exp(L + 1, 24'h000000, F_IDLE, "rej_value0_clear");
    step();
    do_start(2'd3, 4'd5, L);
    push_exp(L,     24'h000000, F_REJ,  "rej_unit3");
    push_exp(L + 1, 24'h000000, F_IDLE, "rej_unit3_clear");
    step();

    // Start during RUN is ignored
    do_start(2'd2, 4'd2, L);
    push_exp(L, 24'h000002, F_BUSY, "ign_load");
    begin
      int L2;
      do_start(2'd2, 4'd7, L2);
    end
    push_exp(L + 1, 24'h000002, F_BUSY,   "ign_start_in_run");
    push_exp(L + 4, 24'h000001, F_BUSY,   "ign_dec");
    push_exp(L + 8, 24'h000000, F_DONE,   "ign_done");
    push_exp(L + 9, 24'h000000, F_EXP,    "ign_expired");
    wait_until(L + 9);
    do_start(2'd2, 4'd0, L);
    push_exp(L,     24'h000000, F_EXPREJ, "rej_in_done");
    push_exp(L + 1, 24'h000000, F_EXP,    "rej_in_done_keeps_expired");
    wait_until(L + 2);

    // Asynchronous reset mid-run at 00:00:02
    do_start(2'd2, 4'd3, L);
    push_exp(L,     24'h000003, F_BUSY, "rst_run_load");
    push_exp(L + 4, 24'h000002, F_BUSY, "rst_run_dec");
    wait_until(L + 5);
    push_exp(L + 5, 24'h000000, F_IDLE, "async_reset_immediate");
    #1 reset = 1'b1;
    #1;
    checks++;
    if (got_t !== 24'h000000 || got_f !== F_IDLE) begin
      errors++;
      $display("FAIL async_reset_direct: got time=%h flags=%b", got_t, got_f);
    end
    step();
    push_exp(L + 6, 24'h000000, F_IDLE, "async_reset_held");
    step();
    reset = 1'b0;
    step();

    // Restart: run 1 s to DONE, then reload from DONE
    do_start(2'd2, 4'd1, L);
    push_exp(L,     24'h000001, F_BUSY, "post_reset_load");
    push_exp(L + 4, 24'h000000, F_DONE, "post_reset_done");
    wait_until(L + 5);
    do_start(2'd2, 4'd1, L);
    push_exp(L,     24'h000001, F_BUSY, "reload_from_done");
    push_exp(L + 3, 24'h000001, F_BUSY, "reload_hold");
    push_exp(L + 4, 24'h000000, F_DONE, "reload_done");
    push_exp(L + 5, 24'h000000, F_EXP,  "reload_expired");
    wait_until(L + 8);

    // Anything still queued was never checked
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cyc %0d never checked", sb[i].name, sb[i].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors != 0) $display("TEST FAILED");
    else             $display("TEST PASSED");
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Downstream consumer of the power-on time-setting stage. Takes one 4-bit setting plus its unit (hours, minutes or seconds), loads it as a countdown, and decrements once per second from a divided board clock. It presents the remaining time as six BCD digits (HH:MM:SS) for the seven-segment display driver, and flags expiry to the control FSM.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per one-second tick; the bench uses 4.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: single-cycle load request; honoured only in IDLE or DONE.
- `unit_sel` in 2: unit of `value`; 0 = hours, 1 = minutes, 2 = seconds, 3 = invalid.
- `value` in 4: setting magnitude, 0–15.
- `pause` in 1: level; while high in RUN, the countdown freezes.
- `cancel` in 1: single-cycle abort/acknowledge.
- `busy` out 1: high in RUN and PAUSED.
- `expired` out 1: level, high in DONE.
- `done` out 1: single-cycle pulse on entry to DONE.
- `rej` out 1: single-cycle pulse when a `start` is rejected.
- `h1 h0 m1 m0 s1 s0` out 4 each: BCD remaining-time digits.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Encoding is free.
- **Reset:** state = IDLE, all digits 0, prescaler 0, and `busy`/`expired`/`done`/`rej` all 0.
- **Load, in IDLE or DONE on `start`:**
  - Hours: h1:h0 = value in BCD (e.g. 12 gives h1=1, h0=2); minutes and seconds = 0.
  - Minutes: m1:m0 = value; hours and seconds = 0.
  - Seconds: s1:s0 = value; hours and minutes = 0.
  - The prescaler clears on load. The next state is RUN.
- **Invalid load:** `start` with `unit_sel`=3 or `value`=0 loads nothing, pulses `rej`, and leaves state unchanged.
- **Start outside IDLE/DONE:** `start` in RUN or PAUSED is ignored, with no `rej`.
- **RUN:** the prescaler counts 0..CLK_HZ-1 and wraps. On the wrap cycle a tick decrements the time by one second:
  - s0 borrows from s1 (s 00→59).
  - s borrows from m (m 00→59).
  - m borrows from h (h wraps 00→…).
  - Hours never go below 00, because a tick at 00:00:01 produces 00:00:00.
- **Reaching zero:** the tick that produces 00:00:00 moves to DONE in the same cycle and asserts `done` for one cycle. Digits stay at 0.
- **PAUSED:** RUN with `pause`=1 enters PAUSED. The prescaler and digits hold. `pause`=0 returns to RUN, and the prescaler resumes from its held count.
- **Cancel:** in any state, `cancel` clears the digits and prescaler and moves to IDLE. It has priority over `start`, `pause` and ticks in the same cycle, and produces no `done`.
- **DONE:** `expired` stays high until `cancel` or a valid `start`. A valid `start` reloads directly into RUN.
- **Same-cycle priority:** cancel > start > pause > tick. A tick coinciding with `pause` rising is discarded, and the prescaler holds at CLK_HZ-1.

## Timing
- All outputs are registered. Response to any input is visible 1 cycle after it is sampled.
- **Load:** `start` sampled at edge t gives digits loaded and `busy`=1 after edge t.
- **First decrement:** visible exactly CLK_HZ cycles after the load edge, then every CLK_HZ cycles while in RUN.
- **Total run time:** N total seconds with no pause gives `done` N·CLK_HZ cycles after the load edge.
- **`done` pulse:** asserted in the same cycle as `expired` rises and `busy` falls.
- **Asynchronous reset:** `reset` assertion immediately forces the reset values, including mid-RUN and mid-`done`.

## Structure
- **Shared package (`timer_pkg`):** the state enum, unit codes `UNIT_H`=0, `UNIT_M`=1, `UNIT_S`=2, and the BCD limit `MAX_SM`=5 for tens-of-seconds/minutes.
- **Sub-module `tick_gen`:**
  - Prescaler parameterised by CLK_HZ.
  - Inputs: `clr`, `en`.
  - Output: 1-cycle `tick` on wrap.
- The BCD borrow chain is a combinational function in the package.

## Test plan
- **Seconds load:** CLK_HZ=4, `start`, unit=2, value=3 → digits 00:00:03. After 4 cycles 00:00:02; after 12 cycles 00:00:00, with `done` for 1 cycle and `expired`=1.
- **Minute borrow:** unit=1, value=2 → 00:02:00. The first tick gives 00:01:59; after 120 ticks `done`.
- **Hour borrow:** unit=0, value=15 → h1=1, h0=5. The first tick gives 14:59:59; `busy` stays 1.
- **Pause and cancel:** assert `pause` for 10 cycles mid-run → digits frozen, and the next decrement arrives 10 cycles late. Then `cancel` together with `start` → IDLE, digits 0, no `done`.
- **Rejected starts:** `start` with value=0, then with unit=3 → `rej` pulses each time, state stays IDLE. `start` during RUN → ignored, no `rej`.
- **Reset and restart:** `reset` asserted mid-RUN at 00:00:02 → outputs zero immediately. After reset, `start` from DONE with unit=2, value=1 → RUN with `expired` cleared, and `done` after 4 cycles.
